// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared sizes and types for the register scoreboard: register address
//   width, register count, in-flight limit and counter width, plus a small
//   up/down step helper used by every 2-bit counter in the block.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W   = 3;
  localparam int NUM_REGS     = 8;
  localparam int MAX_INFLIGHT = 3;
  localparam int CNT_W        = 2;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Net up/down step; callers guarantee the result stays in range.
  function automatic cnt_t step_cnt(input cnt_t v, input logic up, input logic dn);
    return v + cnt_t'(up) - cnt_t'(dn);
  endfunction

endpackage

// File: rtl/pending_counter.sv
// pending_counter
//   Saturating 2-bit pending-write counter for one architectural register.
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous active-low reset, clears the count
//     inc   - one more write pending (accepted issue)
//     dec   - one pending write completed (clean retire)
//     clr   - drop every pending write (flush); wins over inc/dec
//     count - current pending count
//     ovf   - inc requested with count already at max and no dec to offset it
//     unf   - dec requested with count at zero
//   An offending inc or dec is dropped so the counter never wraps; the
//   other half of a simultaneous inc/dec pair still applies.
module pending_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output cnt_t count,
  output logic ovf,
  output logic unf
);

  cnt_t count_q;
  cnt_t count_d;
  logic dec_ok;
  logic inc_ok;

  always_comb begin
    dec_ok  = dec & (count_q != '0);
    // At max, an increment is only legal when a same-cycle decrement frees a slot.
    inc_ok  = inc & ((count_q != '1) | dec_ok);
    unf     = dec & ~dec_ok;
    ovf     = inc & ~inc_ok;
    count_d = clr ? '0 : step_cnt(count_q, inc_ok, dec_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks pending register writes between issue and writeback of an
//   in-order pipeline, blocks issue on read-after-write hazards or a full
//   pipeline, and marks writebacks of flushed instructions as dirty so the
//   register file suppresses them.
//   Ports:
//     clk, rst                 - clock; asynchronous active-low reset
//     issue_valid/wen/wreg     - instruction at issue, its destination
//     issue_rreg1/2, use1/2    - its sources and whether each is read
//     wb_valid/skip/wreg       - instruction retiring, no-write flag, destination
//     flush                    - kill every in-flight instruction not retiring now
//     stall                    - issue blocked this cycle (combinational)
//     wb_dirty                 - retiring instruction was killed (combinational)
//     busy                     - per-register pending-write flags
//     inflight                 - issued, not yet retired instruction count
//     err                      - sticky protocol violation
//   Handshake: an issue is taken on a rising edge where issue_valid=1,
//   stall=0 and flush=0; every taken issue is answered by exactly one later
//   wb_valid pulse, in issue order. wb_valid has no back-pressure.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [REG_ADDR_W-1:0] issue_wreg,
  input  logic [REG_ADDR_W-1:0] issue_rreg1,
  input  logic [REG_ADDR_W-1:0] issue_rreg2,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  input  logic                  wb_valid,
  input  logic                  wb_skip,
  input  logic [REG_ADDR_W-1:0] wb_wreg,
  input  logic                  flush,
  output logic                  stall,
  output logic                  wb_dirty,
  output logic [NUM_REGS-1:0]   busy,
  output logic [CNT_W-1:0]      inflight,
  output logic                  err
);

  cnt_t inflight_q, inflight_d;
  cnt_t kill_cnt_q, kill_cnt_d;
  logic err_q, err_d;

  cnt_t                cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ovf;
  logic [NUM_REGS-1:0] unf;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  logic accept;
  logic wb_ok;
  logic wb_bad;
  logic clean_wr;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) busy[i] = (cnt[i] != '0);
  end

  // Hazard check uses registered state only; a writeback this cycle does
  // not release a waiting reader until the next cycle.
  assign stall = issue_valid &
                 ((issue_use1 & busy[issue_rreg1]) |
                  (issue_use2 & busy[issue_rreg2]) |
                  (inflight_q == cnt_t'(MAX_INFLIGHT)));

  assign accept   = issue_valid & ~stall & ~flush;
  assign wb_dirty = wb_valid & (kill_cnt_q != '0);
  // A writeback with nothing in flight is a violation and is ignored.
  assign wb_bad   = wb_valid & (inflight_q == '0);
  assign wb_ok    = wb_valid & ~wb_bad;
  assign clean_wr = wb_ok & ~wb_dirty & ~wb_skip;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    assign inc[g] = accept & issue_wen & (issue_wreg == reg_addr_t'(g));
    assign dec[g] = clean_wr & (wb_wreg == reg_addr_t'(g));

    pending_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .clr   (flush),
      .count (cnt[g]),
      .ovf   (ovf[g]),
      .unf   (unf[g])
    );
  end

  always_comb begin
    inflight_d = step_cnt(inflight_q, accept, wb_ok);
    kill_cnt_d = step_cnt(kill_cnt_q, 1'b0, wb_ok & wb_dirty);
    if (flush) begin
      // Everything still in flight after this cycle's retire becomes killed.
      inflight_d = step_cnt(inflight_q, 1'b0, wb_ok);
      kill_cnt_d = step_cnt(inflight_q, 1'b0, wb_ok);
    end
    err_d = err_q | wb_bad | (|ovf) | (|unf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      kill_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      kill_cnt_q <= kill_cnt_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//   Directed scenarios plus a short random traffic phase for reg_scoreboard.
//   Inputs change on the falling edge; combinational outputs are sampled 1
//   time unit after driving, registered outputs right after the next
//   falling edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wen, issue_use1, issue_use2;
  logic [2:0] issue_wreg, issue_rreg1, issue_rreg2;
  logic       wb_valid, wb_skip, flush;
  logic [2:0] wb_wreg;
  logic       stall, wb_dirty, err;
  logic [7:0] busy;
  logic [1:0] inflight;

  int errors = 0;
  int checks = 0;

  // Expected wb_dirty of each in-flight instruction, in issue order.
  logic [0:0] exp_q[$];
  logic [0:0] exp_dirty;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_wreg(issue_wreg),
    .issue_rreg1(issue_rreg1), .issue_rreg2(issue_rreg2),
    .issue_use1(issue_use1), .issue_use2(issue_use2),
    .wb_valid(wb_valid), .wb_skip(wb_skip), .wb_wreg(wb_wreg),
    .flush(flush), .stall(stall), .wb_dirty(wb_dirty),
    .busy(busy), .inflight(inflight), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    issue_valid = 0; issue_wen = 0; issue_wreg = 0;
    issue_rreg1 = 0; issue_rreg2 = 0; issue_use1 = 0; issue_use2 = 0;
    wb_valid = 0; wb_skip = 0; wb_wreg = 0; flush = 0;
  endtask

  task automatic set_issue(input logic wen, input logic [2:0] wreg,
                           input logic u1, input logic [2:0] r1,
                           input logic u2, input logic [2:0] r2);
    issue_valid = 1; issue_wen = wen; issue_wreg = wreg;
    issue_use1 = u1; issue_rreg1 = r1; issue_use2 = u2; issue_rreg2 = r2;
  endtask

  task automatic set_wb(input logic skip, input logic [2:0] wreg);
    wb_valid = 1; wb_skip = skip; wb_wreg = wreg;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Empty queue yields X so the following compare reports it.
  task automatic pop_exp(output logic [0:0] v);
    if (exp_q.size() == 0) v = 1'bx;
    else                   v = exp_q.pop_front();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected 00", busy); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (wb_dirty !== 1'b0) begin errors++; $display("FAIL reset_wb_dirty: got %b expected 0", wb_dirty); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_raw_stall();
    set_idle(); set_issue(1, 3'd3, 0, 0, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall: got %b expected 0", stall); end
    exp_q.push_back(1'b0);
    tick();
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL raw_busy: got %h expected 08", busy); end
    set_idle(); set_issue(0, 3'd0, 1, 3'd3, 0, 3'd0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", stall); end
    tick();
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL raw_inflight_held: got %0d expected 1", inflight); end
    // Reader still waiting while r3 retires: no same-cycle bypass.
    set_wb(0, 3'd3);
    #1;
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL raw_wb_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %b expected 1", stall); end
    tick();
    set_idle(); set_issue(0, 3'd0, 1, 3'd3, 0, 3'd0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_released: got %b expected 0", stall); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL raw_busy_clear: got %h expected 00", busy); end
    exp_q.push_back(1'b0);
    tick();
    set_idle(); set_wb(1, 3'd0);
    #1;
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL raw_wb2_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    tick();
    set_idle();
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL raw_drained: got %0d expected 0", inflight); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_issue(0, 3'd0, 0, 0, 0, 0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_issue%0d_stall: got %b expected 0", i, stall); end
      exp_q.push_back(1'b0);
      tick();
    end
    checks++; if (inflight !== 2'd3) begin errors++; $display("FAIL b2b_inflight_full: got %0d expected 3", inflight); end
    set_idle(); set_issue(0, 3'd0, 0, 0, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_full_stall: got %b expected 1", stall); end
    set_wb(1, 3'd0);
    #1;
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL b2b_wb_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_during_wb: got %b expected 1", stall); end
    tick();
    set_idle(); set_issue(0, 3'd0, 0, 0, 0, 0);
    #1;
    checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL b2b_after_retire: got %0d expected 2", inflight); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_unstalled: got %b expected 0", stall); end
    exp_q.push_back(1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_wb(1, 3'd0);
      #1;
      pop_exp(exp_dirty);
      checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL b2b_drain%0d: got %b expected %b", i, wb_dirty, exp_dirty); end
      tick();
    end
    set_idle();
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", inflight); end
  endtask

  task automatic test_flush();
    logic [2:0] regs [3];
    regs[0] = 3'd1; regs[1] = 3'd2; regs[2] = 3'd5;
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_issue(1, regs[i], 0, 0, 0, 0);
      exp_q.push_back(1'b0);
      tick();
    end
    checks++; if (busy !== 8'h26) begin errors++; $display("FAIL flush_busy_before: got %h expected 26", busy); end
    set_idle(); flush = 1;
    for (int i = 0; i < exp_q.size(); i++) exp_q[i] = 1'b1;
    tick();
    set_idle();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL flush_busy_after: got %h expected 00", busy); end
    checks++; if (inflight !== 2'd3) begin errors++; $display("FAIL flush_inflight: got %0d expected 3", inflight); end
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_wb(0, regs[i]);
      #1;
      pop_exp(exp_dirty);
      checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL flush_killed_wb%0d: got %b expected %b", i, wb_dirty, exp_dirty); end
      tick();
    end
    set_idle();
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL flush_inflight_end: got %0d expected 0", inflight); end
    set_issue(1, 3'd1, 0, 0, 0, 0);
    exp_q.push_back(1'b0);
    tick();
    set_idle(); set_wb(0, 3'd1);
    #1;
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL flush_fourth_wb: got %b expected %b", wb_dirty, exp_dirty); end
    tick();
    set_idle();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL flush_busy_end: got %h expected 00", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", err); end
  endtask

  task automatic test_flush_with_wb();
    set_idle(); set_issue(1, 3'd2, 0, 0, 0, 0); exp_q.push_back(1'b0); tick();
    set_idle(); set_issue(1, 3'd3, 0, 0, 0, 0); exp_q.push_back(1'b0); tick();
    set_idle();
    checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL fwb_inflight_before: got %0d expected 2", inflight); end
    // Flush, oldest retiring, and an issue that must be discarded.
    set_issue(1, 3'd7, 0, 0, 0, 0); set_wb(0, 3'd2); flush = 1;
    #1;
    pop_exp(exp_dirty);
    for (int i = 0; i < exp_q.size(); i++) exp_q[i] = 1'b1;
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL fwb_same_cycle_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    tick();
    set_idle();
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL fwb_inflight_after: got %0d expected 1", inflight); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL fwb_busy_after: got %h expected 00", busy); end
    set_wb(0, 3'd3);
    #1;
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL fwb_next_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    tick();
    set_idle();
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL fwb_drained: got %0d expected 0", inflight); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fwb_err: got %b expected 0", err); end
  endtask

  task automatic test_same_cycle();
    set_idle(); set_issue(1, 3'd4, 0, 0, 0, 0); exp_q.push_back(1'b0); tick();
    set_idle(); set_issue(1, 3'd4, 0, 0, 0, 0); set_wb(0, 3'd4);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_stall: got %b expected 0", stall); end
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL same_wb_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    exp_q.push_back(1'b0);
    tick();
    set_idle();
    checks++; if (busy !== 8'h10) begin errors++; $display("FAIL same_busy: got %h expected 10", busy); end
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL same_inflight: got %0d expected 1", inflight); end
    set_wb(0, 3'd4);
    #1;
    pop_exp(exp_dirty);
    checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL same_last_dirty: got %b expected %b", wb_dirty, exp_dirty); end
    tick();
    set_idle();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL same_busy_end: got %h expected 00", busy); end
  endtask

  task automatic test_random_traffic();
    int         m_cnt [8];
    int         m_inflight;
    logic [2:0] q_wreg[$];
    logic       q_wen[$];
    logic       do_iss, do_wb, exp_stall, wen, u1, u2;
    logic [2:0] wreg, r1, r2;
    logic [7:0] exp_busy;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_inflight = 0;
    for (int it = 0; it < 60; it++) begin
      set_idle();
      do_iss = 1'($urandom_range(0, 1));
      do_wb  = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
      exp_stall = 1'b0;
      if (do_iss) begin
        wen = 1'($urandom_range(0, 1)); wreg = 3'($urandom_range(0, 7));
        u1  = 1'($urandom_range(0, 1)); r1   = 3'($urandom_range(0, 7));
        u2  = 1'($urandom_range(0, 1)); r2   = 3'($urandom_range(0, 7));
        set_issue(wen, wreg, u1, r1, u2, r2);
        exp_stall = (u1 && m_cnt[r1] != 0) || (u2 && m_cnt[r2] != 0) || (m_inflight == 3);
      end
      if (do_wb) set_wb(!q_wen[0], q_wreg[0]);
      #1;
      if (do_iss) begin
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall it=%0d: got %b expected %b", it, stall, exp_stall); end
      end
      if (do_wb) begin
        pop_exp(exp_dirty);
        checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL rnd_wb_dirty it=%0d: got %b expected %b", it, wb_dirty, exp_dirty); end
        if (q_wen[0]) m_cnt[q_wreg[0]]--;
        void'(q_wen.pop_front()); void'(q_wreg.pop_front());
        m_inflight--;
      end
      if (do_iss && !exp_stall) begin
        q_wen.push_back(wen); q_wreg.push_back(wreg); exp_q.push_back(1'b0);
        if (wen) m_cnt[wreg]++;
        m_inflight++;
      end
      tick();
      for (int i = 0; i < 8; i++) exp_busy[i] = (m_cnt[i] != 0);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy it=%0d: got %h expected %h", it, busy, exp_busy); end
      checks++; if (inflight !== 2'(m_inflight)) begin errors++; $display("FAIL rnd_inflight it=%0d: got %0d expected %0d", it, inflight, m_inflight); end
    end
    while (m_inflight > 0) begin
      set_idle(); set_wb(!q_wen[0], q_wreg[0]);
      #1;
      pop_exp(exp_dirty);
      checks++; if (wb_dirty !== exp_dirty) begin errors++; $display("FAIL rnd_drain_dirty: got %b expected %b", wb_dirty, exp_dirty); end
      void'(q_wen.pop_front()); void'(q_wreg.pop_front());
      m_inflight--;
      tick();
    end
    set_idle();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL rnd_busy_end: got %h expected 00", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b expected 0", err); end
  endtask

  task automatic test_err();
    set_idle();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b expected 0", err); end
    set_wb(0, 3'd6);
    #1;
    checks++; if (wb_dirty !== 1'b0) begin errors++; $display("FAIL err_stray_dirty: got %b expected 0", wb_dirty); end
    tick();
    set_idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL err_no_wrap: got %0d expected 0", inflight); end
    set_issue(0, 3'd0, 0, 0, 0, 0); tick();
    set_idle(); set_wb(1, 3'd0); tick();
    set_idle(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    // Assert reset between clock edges: must clear without a clock.
    #3;
    rst = 0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_async_clear: got %b expected 0", err); end
    @(negedge clk);
    rst = 1;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_reset: got %b expected 0", err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_raw_stall();
    test_back_to_back();
    test_flush();
    test_flush_with_wb();
    test_same_cycle();
    test_random_traffic();
    test_err();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 issue_valid  input  1  instruction presented at issue this cycle.
REQ-004 issue_wen  input  1  issuing instruction writes a register.
REQ-005 issue_wreg  input  3  destination register of issuing instruction.
REQ-006 issue_rreg1, issue_rreg2  input  3 each  source registers.
REQ-007 issue_use1, issue_use2  input  1 each  source 1/2 actually read.
REQ-008 wb_valid  input  1  one instruction retires at writeback this cycle.
REQ-009 wb_skip  input  1  retiring instruction performs no register write.
REQ-010 wb_wreg  input  3  destination of retiring instruction.
REQ-011 flush  input  1  kill all in-flight instructions not retiring this cycle.
REQ-012 stall  output  1  issue blocked this cycle (combinational).
REQ-013 wb_dirty  output  1  retiring instruction was killed; its write must be suppressed (drives register file dirty).
REQ-014 busy  output  8  bit i = register i has a pending write.
REQ-015 inflight  output  2  issued, not-yet-retired instruction count.
REQ-016 err  output  1  sticky protocol-violation flag.

Function
REQ-017 Every accepted issue produces exactly one later wb_valid pulse; retirement is in issue order.
REQ-018 Per register: 2-bit pending count; busy[i] = (count[i] != 0).
REQ-019 inflight counts 0..MAX_INFLIGHT (3); kill_cnt (2 bits, internal) counts killed instructions still to retire.
REQ-020 stall = issue_valid & ((issue_use1 & busy[issue_rreg1]) | (issue_use2 & busy[issue_rreg2]) | (inflight == 3)); evaluated on registered state only, no same-cycle writeback bypass.
REQ-021 Issue accepted when issue_valid & !stall & !flush: inflight +1; if issue_wen, count[issue_wreg] +1.
REQ-022 wb_dirty = wb_valid & (kill_cnt != 0), combinational, zero latency.
REQ-023 Retire with wb_dirty=1: inflight -1, kill_cnt -1, pending counts untouched.
REQ-024 Retire with wb_dirty=0: inflight -1; if !wb_skip, count[wb_wreg] -1.
REQ-025 Accepted issue and clean retire on same register same cycle: count unchanged (net zero); inflight likewise net zero.
REQ-026 flush: all pending counts cleared to 0; kill_cnt <= inflight - wb_valid; inflight <= inflight - wb_valid; any issue that cycle discarded; the same-cycle wb_valid retires normally per REQ-022..024 against pre-flush state.
REQ-027 err set (and stays set until reset) on: wb_valid with inflight == 0; clean non-skip retire to register with count 0; count increment at 3. Offending update is dropped, no wrap.
REQ-028 No other state; no FSM beyond counters; outputs glitch-free only as combinational functions of registered state and current inputs.

Reset
REQ-029 rst=0 asynchronously clears all pending counts, inflight, kill_cnt, err; thus busy=0, inflight=0, err=0, wb_dirty=0, stall=0 with inputs idle.
REQ-030 Reset mid-operation abandons all in-flight tracking; pipeline is reset concurrently, so no post-reset writebacks for pre-reset instructions are expected.
REQ-031 Reset deassertion requires no synchronizer inside the block; first update on first rising clk after rst=1.

Structure
REQ-032 Shared defines file holds REG_ADDR_W=3, NUM_REGS=8, MAX_INFLIGHT=3, CNT_W=2.
REQ-033 One sub-module pending_counter (saturating 2-bit up/down/clear, overflow/underflow flags), instantiated 8 times.
REQ-034 reg_scoreboard sits beside the read/write unit; its wb_dirty connects to that unit's dirty input, wb_skip shared.

Verification
REQ-035 Issue wen r3, next cycle issue using r3 -> stall=1, busy=8'h08; clean wb r3 -> following cycle stall=0, busy=0.
REQ-036 Issue 3 instructions back-to-back -> inflight=3, 4th issue stall=1; one retire -> inflight=2, stall=0 next cycle.
REQ-037 Issue wen r1, r2, r5; flush with no wb -> busy=0, next 3 wb_valid give wb_dirty=1, 4th gives 0, inflight ends 0.
REQ-038 Flush coincident with wb_valid, inflight=2 -> that wb_dirty=0, kill_cnt=1, next wb_dirty=1.
REQ-039 Same-cycle accepted issue wen r4 and clean retire r4 with count 1 -> count stays 1, busy[4]=1.
REQ-040 wb_valid with inflight=0 -> err=1, held through later traffic, cleared only by rst=0 applied mid-cycle (async).
